// File: rtl/mux_share_arbiter.sv
// Round-robin owner of the shared 2:1 registered mux between requesters A and B.
// Grants are capped at MAX_HOLD beats only while the other side is waiting.
module mux_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [CNT_W-1:0] beats_a,
    output logic [CNT_W-1:0] beats_b
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B
    } state_t;

    state_t        state;
    logic          last;
    logic [HW-1:0] hold_cnt;

    logic own_req;
    logic oth_req;
    logic at_cap;
    logic xfer;
    logic go_a;
    logic go_b;
    logic go_idle;
    logic hold_inc;

    always_comb begin
        own_req = 1'b0;
        oth_req = 1'b0;
        unique case (state)
            GRANT_A: begin
                own_req = req_a;
                oth_req = req_b;
            end
            GRANT_B: begin
                own_req = req_b;
                oth_req = req_a;
            end
            default: ;
        endcase
    end

    assign xfer   = own_req;
    assign at_cap = (hold_cnt == HOLD_MAX);

    // last=1 means B was served most recently, so A wins a tie.
    always_comb begin
        go_a     = 1'b0;
        go_b     = 1'b0;
        go_idle  = 1'b0;
        hold_inc = 1'b0;
        unique case (state)
            IDLE: begin
                go_a = req_a && (!req_b || last);
                go_b = req_b && !go_a;
            end
            GRANT_A: begin
                go_b     = oth_req && (!own_req || at_cap);
                go_idle  = !own_req && !oth_req;
                hold_inc = own_req && !go_b && !at_cap;
            end
            GRANT_B: begin
                go_a     = oth_req && (!own_req || at_cap);
                go_idle  = !own_req && !oth_req;
                hold_inc = own_req && !go_a && !at_cap;
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= 1'b0;
            y        <= '0;
            y_valid  <= 1'b0;
            beats_a  <= '0;
            beats_b  <= '0;
        end else begin
            y_valid <= xfer;
            if (xfer) begin
                y <= sel ? b : a;
                if (sel) beats_b <= beats_b + CNT_W'(1);
                else     beats_a <= beats_a + CNT_W'(1);
            end
            unique case (1'b1)
                go_a: begin
                    state    <= GRANT_A;
                    gnt_a    <= 1'b1;
                    gnt_b    <= 1'b0;
                    sel      <= 1'b0;
                    last     <= 1'b0;
                    hold_cnt <= '0;
                end
                go_b: begin
                    state    <= GRANT_B;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b1;
                    sel      <= 1'b1;
                    last     <= 1'b1;
                    hold_cnt <= '0;
                end
                go_idle: begin
                    state    <= IDLE;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    sel      <= 1'b0;
                    hold_cnt <= '0;
                end
                hold_inc: hold_cnt <= hold_cnt + HW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: three parameterisations driven in lockstep,
// checked against a beat-level model, a vector table and directed sequences.
module tb_mux_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    always #5 clk = ~clk;

    logic        ga0, gb0, sl0, v0;
    logic [7:0]  y0;
    logic [15:0] ba0, bb0;
    logic        ga1, gb1, sl1, v1;
    logic [7:0]  y1;
    logic [15:0] ba1, bb1;
    logic        ga2, gb2, sl2, v2;
    logic [7:0]  y2;
    logic [3:0]  ba2, bb2;

    mux_share_arbiter #(.WIDTH(8), .MAX_HOLD(4), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(ga0), .gnt_b(gb0), .sel(sl0), .y(y0), .y_valid(v0),
        .beats_a(ba0), .beats_b(bb0));

    mux_share_arbiter #(.WIDTH(8), .MAX_HOLD(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(ga1), .gnt_b(gb1), .sel(sl1), .y(y1), .y_valid(v1),
        .beats_a(ba1), .beats_b(bb1));

    mux_share_arbiter #(.WIDTH(8), .MAX_HOLD(4), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(ga2), .gnt_b(gb2), .sel(sl2), .y(y2), .y_valid(v2),
        .beats_a(ba2), .beats_b(bb2));

    logic [43:0] obs [3];
    assign obs[0] = {ga0, gb0, sl0, v0, y0, ba0, bb0};
    assign obs[1] = {ga1, gb1, sl1, v1, y1, ba1, bb1};
    assign obs[2] = {ga2, gb2, sl2, v2, y2, 12'h000, ba2, 12'h000, bb2};

    int ncmp = 0;
    int nbad = 0;

    task automatic cmp(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=A 2=B, served = beats in the current grant.
    int mh [3] = '{4, 1, 4};
    int cw [3] = '{16, 16, 4};
    int own [3];
    int lst [3];
    int served [3];
    int mba [3];
    int mbb [3];
    logic [7:0] my [3];
    bit myv [3];

    task automatic mreset(input int i);
        own[i] = 0;
        lst[i] = 2;
        served[i] = 0;
        mba[i] = 0;
        mbb[i] = 0;
        my[i] = 8'h00;
        myv[i] = 1'b0;
    endtask

    task automatic mreset_all();
        for (int i = 0; i < 3; i++) mreset(i);
    endtask

    task automatic mstep();
        for (int i = 0; i < 3; i++) begin
            bit rx;
            bit ro;
            if (!rst) begin
                mreset(i);
            end else if (own[i] == 0) begin
                myv[i] = 1'b0;
                if (req_a && req_b) own[i] = (lst[i] == 2) ? 1 : 2;
                else if (req_a) own[i] = 1;
                else if (req_b) own[i] = 2;
                if (own[i] != 0) begin
                    lst[i] = own[i];
                    served[i] = 0;
                end
            end else begin
                rx = (own[i] == 1) ? req_a : req_b;
                ro = (own[i] == 1) ? req_b : req_a;
                if (!rx) begin
                    myv[i] = 1'b0;
                    if (ro) begin
                        own[i] = 3 - own[i];
                        lst[i] = own[i];
                        served[i] = 0;
                    end else begin
                        own[i] = 0;
                    end
                end else begin
                    myv[i] = 1'b1;
                    my[i] = (own[i] == 1) ? a : b;
                    if (own[i] == 1) mba[i] = (mba[i] + 1) % (1 << cw[i]);
                    else             mbb[i] = (mbb[i] + 1) % (1 << cw[i]);
                    served[i]++;
                    if (served[i] >= mh[i] && ro) begin
                        own[i] = 3 - own[i];
                        lst[i] = own[i];
                        served[i] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [43:0] mexp(input int i);
        return {own[i] == 1, own[i] == 2, own[i] == 2, myv[i], my[i],
                16'(mba[i]), 16'(mbb[i])};
    endfunction

    task automatic cycle();
        @(posedge clk);
        mstep();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            cmp($sformatf("model%0d", i), 64'(obs[i]), 64'(mexp(i)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        mreset_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int rs, ra, rb, va, vb;
        int ega, egb, ev, ey, eba, ebb;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input int rs, ra, rb, va, vb,
                                input int ega, egb, ev, ey, eba, ebb);
        vec_t v;
        v = '{rs, ra, rb, va, vb, ega, egb, ev, ey, eba, ebb};
        tbl.push_back(v);
    endfunction

    initial begin
        // A alone, six beats with incrementing data, then release.
        add(1, 1, 0, 'h10, 0, 1, 0, 0, 'h00, 0, 0);
        add(0, 1, 0, 'h10, 0, 1, 0, 1, 'h10, 1, 0);
        add(0, 1, 0, 'h11, 0, 1, 0, 1, 'h11, 2, 0);
        add(0, 1, 0, 'h12, 0, 1, 0, 1, 'h12, 3, 0);
        add(0, 1, 0, 'h13, 0, 1, 0, 1, 'h13, 4, 0);
        add(0, 1, 0, 'h14, 0, 1, 0, 1, 'h14, 5, 0);
        add(0, 1, 0, 'h15, 0, 1, 0, 1, 'h15, 6, 0);
        add(0, 0, 0, 'h15, 0, 0, 0, 0, 'h15, 6, 0);
        // Both requesting from reset: 4 A, 4 B, 4 A, no bubble.
        add(1, 1, 1, 'hAA, 'hBB, 1, 0, 0, 'h00, 0, 0);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 1, 0);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 2, 0);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 3, 0);
        add(0, 1, 1, 'hAA, 'hBB, 0, 1, 1, 'hAA, 4, 0);
        add(0, 1, 1, 'hAA, 'hBB, 0, 1, 1, 'hBB, 4, 1);
        add(0, 1, 1, 'hAA, 'hBB, 0, 1, 1, 'hBB, 4, 2);
        add(0, 1, 1, 'hAA, 'hBB, 0, 1, 1, 'hBB, 4, 3);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hBB, 4, 4);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 5, 4);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 6, 4);
        add(0, 1, 1, 'hAA, 'hBB, 1, 0, 1, 'hAA, 7, 4);
        add(0, 1, 1, 'hAA, 'hBB, 0, 1, 1, 'hAA, 8, 4);

        mreset_all();
        repeat (2) @(negedge clk);
        cmp("reset_state", 64'(obs[0]), 64'd0);
        rst = 1'b1;

        foreach (tbl[k]) begin
            if (tbl[k].rs != 0) do_reset();
            req_a = 1'(tbl[k].ra);
            req_b = 1'(tbl[k].rb);
            a = 8'(tbl[k].va);
            b = 8'(tbl[k].vb);
            cycle();
            cmp($sformatf("tbl%0d", k), 64'(obs[0]),
                64'({1'(tbl[k].ega), 1'(tbl[k].egb), 1'(tbl[k].egb),
                     1'(tbl[k].ev), 8'(tbl[k].ey),
                     16'(tbl[k].eba), 16'(tbl[k].ebb)}));
        end

        // B alone, A joins after two beats: B capped at four.
        do_reset();
        req_b = 1'b1;
        b = 8'h5B;
        repeat (3) cycle();
        req_a = 1'b1;
        a = 8'h5A;
        repeat (2) cycle();
        cmp("b_capped", 64'({ga0, bb0}), 64'({1'b1, 16'd4}));
        cycle();
        req_a = 1'b0;
        cycle();
        cmp("a_drop_to_b", 64'({gb0, v0, ba0}), 64'({1'b1, 1'b0, 16'd1}));
        req_b = 1'b0;
        cycle();
        cmp("both_drop_idle", 64'({ga0, gb0, v0}), 64'd0);

        // Asynchronous reset during A's third beat.
        do_reset();
        req_a = 1'b1;
        a = 8'h31;
        repeat (4) cycle();
        cmp("pre_rst_beats", 64'(ba0), 64'd3);
        #2;
        rst = 1'b0;
        mreset_all();
        #1;
        cmp("async_rst", 64'(obs[0]), 64'd0);
        req_b = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cmp("rst_a_first", 64'({ga0, gb0}), 64'({1'b1, 1'b0}));

        // CNT_W=4: eighteen B beats wrap the counter to 2.
        do_reset();
        req_b = 1'b1;
        b = 8'h77;
        cycle();
        for (int k = 1; k <= 18; k++) begin
            cycle();
            cmp("wrap_run", 64'({gb2, v2}), 64'({1'b1, 1'b1}));
        end
        cmp("wrap_cnt", 64'(bb2), 64'd2);

        // MAX_HOLD=1: strict alternation.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        a = 8'h11;
        b = 8'h22;
        cycle();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            cmp("alt_y", 64'(y1), (k % 2 == 1) ? 64'h11 : 64'h22);
        end
        cmp("alt_cnt", 64'({ba1, bb1}), 64'({16'd4, 16'd4}));

        // Random traffic with persistent requests and rare resets.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) req_a = ~req_a;
            if ($urandom_range(0, 3) == 0) req_b = ~req_b;
            a = 8'($urandom);
            b = 8'($urandom);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                mreset_all();
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter/controller that shares the team's 2:1 registered mux datapath between two requesters (A and B).
- Each requester holds a request line and its data. The block drives the mux select, grants one requester at a time and caps every grant at MAX_HOLD beats while the other side waits.
- Produces the muxed output with a valid strobe, plus per-requester beat counters for the test environment.
- Sits between the requester-side interfaces and the shared mux output consumer.

Parameters:
- WIDTH, 8, data width of a, b and y.
- MAX_HOLD, 4, maximum consecutive beats per grant when the other requester is waiting (>=1).
- CNT_W, 16, width of the per-requester beat counters.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants transfers. Held high while it has data.
- req_b  input  1  requester B request.
- a  input  WIDTH  requester A data, must be stable while gnt_a && req_a.
- b  input  WIDTH  requester B data.
- gnt_a  output  1  A currently owns the mux.
- gnt_b  output  1  B currently owns the mux.
- sel  output  1  mux select: 0 = a, 1 = b.
- y  output  WIDTH  registered muxed data.
- y_valid  output  1  y holds a beat transferred on the previous edge.
- beats_a  output  CNT_W  count of A beats transferred, wraps modulo 2^CNT_W.
- beats_b  output  CNT_W  count of B beats transferred.

Behaviour:
- FSM states: IDLE, GRANT_A, GRANT_B. Moore outputs:
  - gnt_a = (state==GRANT_A)
  - gnt_b = (state==GRANT_B)
  - sel = (state==GRANT_B)
- Registers:
  - state
  - last (last granted side, A/B)
  - hold_cnt (0..MAX_HOLD-1)
  - y, y_valid, beats_a, beats_b
- Reset (rst=0, async, any time including mid-burst):
  - state=IDLE, last=B, hold_cnt=0.
  - gnt_a=gnt_b=sel=0, y=0, y_valid=0, beats_a=beats_b=0.
  - Resumes cleanly on the first edge after rst deasserts.
- IDLE transitions:
  - Only req_a -> GRANT_A.
  - Only req_b -> GRANT_B.
  - Both -> the side != last.
  - Neither -> stay.
  - On any grant entry: last updated to that side, hold_cnt=0.
- Transfer condition: an edge in GRANT_x with req_x=1 transfers one beat. On that edge:
  - y <= (sel ? b : a)
  - y_valid <= 1
  - beats_x++ (wrapping)
- Any edge without a transfer: y_valid <= 0 and y holds its value.
- Latency:
  - Request to first grant: 1 cycle, since req is sampled at edge N and gnt is high after edge N.
  - First y_valid: after edge N+1.
  - Steady throughput: 1 beat/cycle.
- GRANT_x transitions, evaluated per edge (other = the opposite requester):
  - req_x=0 and req_other=1 -> GRANT_other directly, no IDLE bubble.
  - req_x=0 and req_other=0 -> IDLE.
  - Transfer with hold_cnt==MAX_HOLD-1 and req_other=1 -> GRANT_other (beat still transferred).
  - Transfer otherwise -> stay. hold_cnt increments, saturating at MAX_HOLD-1.
    - With no competitor the grant is unlimited.
    - Once the competitor appears, the grant switches after the next beat.
- MAX_HOLD=1: strict alternation whenever both requesters are active.
- Simultaneous events:
  - req_x drop and req_other rise on the same edge: the switch happens, no transfer that edge.
- Invariants:
  - gnt_a and gnt_b are never both high.
  - sel never changes while y_valid is being generated from a different side's data.
  - Beats are never lost or duplicated: beats_a + beats_b equals the number of y_valid pulses (mod 2^CNT_W).

Test Plan:
- Reset then req_a=1 for 6 cycles, a=0x10..0x15 incrementing -> gnt_a after 1 edge, y_valid for 6 cycles with y=0x10..0x15, sel=0, beats_a=6, beats_b=0.
- Both req_a and req_b high from reset, MAX_HOLD=4, continuous -> A wins first.
  - Grant pattern: 4 A beats, 4 B beats, 4 A beats, no idle cycle between grants.
  - sel toggles exactly at each switch.
- B granted alone, A requests after 2 beats, MAX_HOLD=4 -> B is capped at 4 beats, then A granted.
  - A drops req after 1 beat -> back to B if req_b is high, else IDLE with y_valid=0.
- Assert rst=0 mid-burst (3rd beat of A) -> all outputs 0 immediately, without waiting for clk.
  - After release with both requesting -> A granted first (last=B).
- CNT_W=4, req_b held for 18 beats alone -> beats_b wraps to 2, y_valid continuous, gnt_b never drops.
- MAX_HOLD=1, both requesting 8 cycles -> y alternates a,b,a,b… and beats_a=beats_b=4.
